// File: rtl/l1_l2_arbiter.sv
// Arbitrates I-L1 and D-L1 line misses/writebacks onto one shared L2 port, one transaction in flight.
// Optional ARB_ROUND_ROBIN_EN: alternate tie grants instead of fixed D-over-I priority.
module l1_l2_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic pick_dcache;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = D-L1 was granted last; reset value 0 makes the first tie go to D
    logic last_grant_q, last_grant_d;

    assign pick_dcache = d_req & (~i_req | ~last_grant_q);
`else
    assign pick_dcache = d_req;
`endif

    // State and transaction latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Grant, L2 strobes and client completion
    always_comb begin
        state_d          = state_q;
        op_write_d       = op_write_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d     = last_grant_q;
`endif
        l2_read          = 1'b0;
        l2_write         = 1'b0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_dcache) begin
                    state_d    = SERVE_D;
                    op_write_d = dcache_pmem_write;
                    addr_d     = dcache_pmem_address;
                    if (dcache_pmem_write) begin
                        wdata_d = dcache_pmem_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d    = SERVE_I;
                    op_write_d = 1'b0;
                    addr_d     = icache_pmem_address;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            SERVE_I: begin
                l2_read  = ~op_write_q;
                l2_write = op_write_q;
                if (l2_resp) begin
                    icache_pmem_resp = 1'b1;
                    state_d          = DONE;
                end
            end
            SERVE_D: begin
                l2_read  = ~op_write_q;
                l2_write = op_write_q;
                if (l2_resp) begin
                    dcache_pmem_resp = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                // One quiet cycle lets the served client drop its request
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign l2_address        = addr_q;
    assign l2_wdata          = wdata_q;
    assign icache_pmem_rdata = l2_rdata;
    assign dcache_pmem_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Directed bench for l1_l2_arbiter: per-cycle vector table plus hand sequences for
// tie order, mid-transaction changes and reset; tie order follows ARB_ROUND_ROBIN_EN.
module tb_l1_l2_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         icache_pmem_read;
    logic [15:0]  icache_pmem_address;
    logic [127:0] icache_pmem_rdata;
    logic         icache_pmem_resp;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [15:0]  dcache_pmem_address;
    logic [127:0] dcache_pmem_wdata;
    logic [127:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;

    int total;
    int bad;

    l1_l2_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .l2_read             (l2_read),
        .l2_write            (l2_write),
        .l2_address          (l2_address),
        .l2_wdata            (l2_wdata),
        .l2_rdata            (l2_rdata),
        .l2_resp             (l2_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ir;
        logic [15:0]  ia;
        logic         dr;
        logic         dw;
        logic [15:0]  da;
        logic [127:0] wd;
        logic [127:0] rdata;
        logic         resp;
        logic         e_rd;
        logic         e_wr;
        logic [15:0]  e_addr;
        logic [127:0] e_wd;
        logic         e_ir;
        logic         e_dr;
    } vec_t;

    localparam int NV = 19;
    vec_t vt[NV];

    localparam logic [127:0] LA5 = {16{8'hA5}};
    localparam logic [127:0] L11 = {16{8'h11}};
    localparam logic [127:0] L22 = {16{8'h22}};
    localparam logic [127:0] WD1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] WD2 = 128'hFEDCBA9876543210FEDCBA9876543210;

    function automatic vec_t mk(input logic ir, input logic [15:0] ia,
                                input logic dr, input logic dw, input logic [15:0] da,
                                input logic [127:0] wd, input logic [127:0] rdata, input logic resp,
                                input logic e_rd, input logic e_wr, input logic [15:0] e_addr,
                                input logic [127:0] e_wd, input logic e_ir, input logic e_dr);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd;
        v.rdata = rdata; v.resp = resp;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icache_pmem_read    = 1'b0;
        icache_pmem_address = '0;
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = '0;
        dcache_pmem_wdata   = '0;
        l2_rdata            = '0;
        l2_resp             = 1'b0;
    endtask

    task automatic chk_strobes(input string tag, input logic rd, input logic wr,
                               input logic ir, input logic dr);
        chk({tag, " l2_read"},  128'(l2_read),  128'(rd));
        chk({tag, " l2_write"}, 128'(l2_write), 128'(wr));
        chk({tag, " i_resp"},   128'(icache_pmem_resp), 128'(ir));
        chk({tag, " d_resp"},   128'(dcache_pmem_resp), 128'(dr));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();

        //          ir  ia        dr  dw  da        wd    rdata resp  rd  wr  addr      wd    ir  dr
        vt[0]  = mk(0, 16'h0000, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[1]  = mk(1, 16'h1000, 1, 0, 16'h2000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[2]  = mk(1, 16'h1000, 1, 0, 16'h2000, '0,   '0,   0,    1,  0,  16'h2000, '0,   0,  0);
        vt[3]  = mk(1, 16'h1000, 1, 0, 16'h2000, '0,   L11,  1,    1,  0,  16'h2000, '0,   0,  1);
        vt[4]  = mk(1, 16'h1000, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[5]  = mk(1, 16'h1000, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[6]  = mk(1, 16'h1000, 0, 0, 16'h0000, '0,   '0,   0,    1,  0,  16'h1000, '0,   0,  0);
        vt[7]  = mk(1, 16'h1000, 0, 0, 16'h0000, '0,   L22,  1,    1,  0,  16'h1000, '0,   1,  0);
        vt[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[9]  = mk(1, 16'h1230, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[10] = mk(1, 16'h1230, 0, 0, 16'h0000, '0,   '0,   0,    1,  0,  16'h1230, '0,   0,  0);
        vt[11] = mk(1, 16'h1230, 0, 0, 16'h0000, '0,   '0,   0,    1,  0,  16'h1230, '0,   0,  0);
        vt[12] = mk(1, 16'h1230, 0, 0, 16'h0000, '0,   LA5,  1,    1,  0,  16'h1230, '0,   1,  0);
        vt[13] = mk(0, 16'h0000, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[14] = mk(0, 16'h0000, 0, 1, 16'h4000, WD1,  '0,   0,    0,  0,  16'h0000, '0,   0,  0);
        vt[15] = mk(0, 16'h0000, 0, 1, 16'h4000, WD1,  '0,   0,    0,  1,  16'h4000, WD1,  0,  0);
        vt[16] = mk(0, 16'h0000, 0, 1, 16'h4000, WD1,  '0,   0,    0,  1,  16'h4000, WD1,  0,  0);
        vt[17] = mk(0, 16'h0000, 0, 1, 16'h4000, WD1,  '0,   1,    0,  1,  16'h4000, WD1,  0,  1);
        vt[18] = mk(0, 16'h0000, 0, 0, 16'h0000, '0,   '0,   0,    0,  0,  16'h0000, '0,   0,  0);

        // Reset values
        tick();
        tick();
        chk_strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset l2_address", 128'(l2_address), 128'h0);
        chk("reset l2_wdata", l2_wdata, 128'h0);

        // Table: drive just after the edge, sample mid-cycle
        for (int i = 0; i < NV; i++) begin
            tick();
            reset               = 1'b0;
            icache_pmem_read    = vt[i].ir;
            icache_pmem_address = vt[i].ia;
            dcache_pmem_read    = vt[i].dr;
            dcache_pmem_write   = vt[i].dw;
            dcache_pmem_address = vt[i].da;
            dcache_pmem_wdata   = vt[i].wd;
            l2_rdata            = vt[i].rdata;
            l2_resp             = vt[i].resp;
            #3;
            chk_strobes($sformatf("v%0d", i), vt[i].e_rd, vt[i].e_wr, vt[i].e_ir, vt[i].e_dr);
            chk($sformatf("v%0d i_rdata", i), icache_pmem_rdata, vt[i].rdata);
            chk($sformatf("v%0d d_rdata", i), dcache_pmem_rdata, vt[i].rdata);
            if (vt[i].e_rd || vt[i].e_wr)
                chk($sformatf("v%0d l2_address", i), 128'(l2_address), 128'(vt[i].e_addr));
            if (vt[i].e_wr)
                chk($sformatf("v%0d l2_wdata", i), l2_wdata, vt[i].e_wd);
        end

        // Second tie: last grant was D, so round robin picks I first
        tick();
        idle_inputs();
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h1100;
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 16'h2200;
        tick();
        #3;
        chk("tie2 first addr", 128'(l2_address), RR ? 128'h1100 : 128'h2200);
        chk_strobes("tie2 first", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        l2_resp = 1'b1;
        #3;
        chk_strobes("tie2 first resp", 1'b1, 1'b0, RR, ~RR);
        tick();
        l2_resp = 1'b1;
        if (RR) icache_pmem_read = 1'b0;
        else    dcache_pmem_read = 1'b0;
        #3;
        chk_strobes("tie2 done ignores resp", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        l2_resp = 1'b0;
        tick();
        #3;
        chk("tie2 second addr", 128'(l2_address), RR ? 128'h2200 : 128'h1100);
        chk_strobes("tie2 second", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        l2_resp = 1'b1;
        #3;
        chk_strobes("tie2 second resp", 1'b1, 1'b0, ~RR, RR);
        tick();
        idle_inputs();
        tick();

        // D address changes and request drops mid-transaction
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 16'h3330;
        tick();
        dcache_pmem_address = 16'h5550;
        #3;
        chk("dchg addr held 1", 128'(l2_address), 128'h3330);
        chk_strobes("dchg serve", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        dcache_pmem_read = 1'b0;
        #3;
        chk("dchg addr held 2", 128'(l2_address), 128'h3330);
        chk("dchg still reading", 128'(l2_read), 128'h1);
        tick();
        l2_resp = 1'b1;
        #3;
        chk("dchg addr at resp", 128'(l2_address), 128'h3330);
        chk_strobes("dchg resp", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle_inputs();
        tick();

        // Read and write together decode as a write
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 16'h6000;
        dcache_pmem_wdata   = WD2;
        tick();
        #3;
        chk_strobes("rw serve", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rw wdata", l2_wdata, WD2);
        chk("rw addr", 128'(l2_address), 128'h6000);
        tick();
        l2_resp = 1'b1;
        #3;
        chk_strobes("rw resp", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle_inputs();
        tick();

        // Reset two cycles into SERVE_I, then a stray l2_resp
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h7770;
        tick();
        #3;
        chk("rst serve read", 128'(l2_read), 128'h1);
        tick();
        reset            = 1'b1;
        icache_pmem_read = 1'b0;
        #1;
        chk_strobes("rst async drop", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        l2_resp = 1'b1;
        #3;
        chk_strobes("rst stray resp", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        l2_resp = 1'b0;
        #3;
        chk_strobes("rst stays idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Arbitrates the instruction L1 cache and the data L1 cache onto the single shared L2 port.
- Each L1 miss or writeback moves one 128-bit line (lc3b_mem_data) at a 16-bit line address (lc3b_word).
- Sits directly downstream of both L1 caches (9-bit tag / 3-bit index / 4-bit offset) and upstream of the L2 (7-bit tag / 4-bit index / 5-bit offset).
- Holds one transaction in flight; latches the granted request so L2 inputs stay stable until l2_resp.

Parameters:
ADDR_WIDTH, 16, line address width (lc3b_word)
LINE_WIDTH, 128, line data width (lc3b_mem_data)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
icache_pmem_read  in  1  I-L1 line read request, held until its resp
icache_pmem_address  in  ADDR_WIDTH  I-L1 line address
icache_pmem_rdata  out  LINE_WIDTH  read line to I-L1
icache_pmem_resp  out  1  one-cycle completion pulse to I-L1
dcache_pmem_read  in  1  D-L1 line read request
dcache_pmem_write  in  1  D-L1 line write request
dcache_pmem_address  in  ADDR_WIDTH  D-L1 line address
dcache_pmem_wdata  in  LINE_WIDTH  D-L1 write line
dcache_pmem_rdata  out  LINE_WIDTH  read line to D-L1
dcache_pmem_resp  out  1  one-cycle completion pulse to D-L1
l2_read  out  1  read strobe to L2
l2_write  out  1  write strobe to L2
l2_address  out  ADDR_WIDTH  latched address to L2
l2_wdata  out  LINE_WIDTH  latched write line to L2
l2_rdata  in  LINE_WIDTH  L2 read line
l2_resp  in  1  L2 completion, one-cycle pulse

Behaviour:
- Reset (async, active-high): state=IDLE. l2_read, l2_write, l2_address, l2_wdata, both *_resp and the latches are 0; last_grant=I.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE:
  - On each clock edge, sample requests.
  - D-request pending (read or write) and I idle -> SERVE_D. I-request pending and D idle -> SERVE_I. Both pending -> SERVE_D.
  - On the grant edge, latch address, operation and (D write only) wdata.
- D operation decode: dcache_pmem_write=1 selects a write. Read+write asserted together is treated as a write.
- SERVE_x:
  - l2_read or l2_write is driven from the latched op; l2_address and l2_wdata come from the latches.
  - All L2 inputs are stable until l2_resp.
  - On l2_resp, the granted client's resp=1 combinationally in the same cycle. Next state=DONE.
- DONE: all L2 strobes 0 for exactly one cycle so the client can drop its request, then IDLE.
- Latency: request visible at edge N -> L2 strobe from cycle N+1. Client resp is coincident with l2_resp. Next grant is sampled no earlier than 2 cycles after l2_resp.
- Read data: l2_rdata is broadcast to both icache_pmem_rdata and dcache_pmem_rdata. Only *_resp qualifies it. The non-granted resp is always 0.
- l2_resp in IDLE or DONE is ignored; no resp is forwarded.
- A client deasserting its request mid-transaction does not abort it. The latched transaction completes and the resp is still pulsed.
- Reset mid-transaction: immediate return to IDLE, strobes drop asynchronously. A late l2_resp is ignored.
- At most one of l2_read/l2_write is high at any time.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a last_grant register updates at each grant. When both clients request in IDLE, grant goes to the client not granted last. After reset the first tie goes to D. Single requests behave as in fixed priority.
- Undefined: fixed priority, D always wins ties. No last_grant register is synthesized. I may be starved by back-to-back D traffic.

Test Plan:
- I read alone: icache_pmem_read=1, address 0x1230; L2 returns l2_rdata=0xA5..A5 after 3 cycles -> l2_read=1 with l2_address=0x1230 from cycle 1; icache_pmem_resp=1 for one cycle with icache_pmem_rdata=0xA5..A5; dcache_pmem_resp stays 0.
- D write alone: address 0x4000, wdata 0x0123..EF -> l2_write=1, l2_address=0x4000, l2_wdata=0x0123..EF held until l2_resp; dcache_pmem_resp pulses once; l2_read stays 0.
- Simultaneous I read (0x1000) and D read (0x2000) -> D served first (l2_address=0x2000), DONE for one cycle, then I served (0x1000). With ARB_ROUND_ROBIN_EN, a second simultaneous pair is granted to I first.
- D changes its address to 0x5550 mid-SERVE_D (was 0x3330) -> l2_address stays 0x3330 until l2_resp.
- Reset asserted 2 cycles into SERVE_I -> l2_read drops immediately, state=IDLE; a subsequent stray l2_resp produces no client resp.
